// File: rtl/pd_rx_framer_pkg.sv
// Shared definitions for the USB-PD receive framer: line codes, ordered-set
// matching, 4b5b decode and CRC32 constants.
package pd_rx_framer_pkg;

    localparam logic [4:0] K_SYNC1 = 5'b11000;
    localparam logic [4:0] K_SYNC2 = 5'b10001;
    localparam logic [4:0] K_SYNC3 = 5'b00110;
    localparam logic [4:0] K_RST1  = 5'b00111;
    localparam logic [4:0] K_RST2  = 5'b11001;
    localparam logic [4:0] K_EOP   = 5'b01101;

    localparam logic [31:0] CRC_POLY_REFL = 32'hEDB88320;
    localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC_RESIDUE   = 32'hDEBB20E3;

    localparam int MIN_FRAME_BYTES = 6;

    typedef enum logic [2:0] {
        SOP_T      = 3'd0,
        SOP_P      = 3'd1,
        SOP_PP     = 3'd2,
        SOP_P_DBG  = 3'd3,
        SOP_PP_DBG = 3'd4
    } sop_t;

    typedef enum logic [0:0] {
        ST_HUNT = 1'b0,
        ST_RECV = 1'b1
    } state_t;

    typedef struct packed {
        logic       vld;
        logic [3:0] nib;
    } dec_t;

    function automatic dec_t dec_4b5b(input logic [4:0] s);
        dec_t d;
        d.vld = 1'b1;
        case (s)
            5'b11110: d.nib = 4'h0;
            5'b01001: d.nib = 4'h1;
            5'b10100: d.nib = 4'h2;
            5'b10101: d.nib = 4'h3;
            5'b01010: d.nib = 4'h4;
            5'b01011: d.nib = 4'h5;
            5'b01110: d.nib = 4'h6;
            5'b01111: d.nib = 4'h7;
            5'b10010: d.nib = 4'h8;
            5'b10011: d.nib = 4'h9;
            5'b10110: d.nib = 4'hA;
            5'b10111: d.nib = 4'hB;
            5'b11010: d.nib = 4'hC;
            5'b11011: d.nib = 4'hD;
            5'b11100: d.nib = 4'hE;
            5'b11101: d.nib = 4'hF;
            default: begin
                d.vld = 1'b0;
                d.nib = 4'h0;
            end
        endcase
        return d;
    endfunction

    // Slot 0 (w[4:0]) is the oldest symbol; a set matches with any three slots exact.
    function automatic logic os_match(input logic [19:0] w, input logic [4:0] s0,
                                      input logic [4:0] s1, input logic [4:0] s2,
                                      input logic [4:0] s3);
        logic [2:0] hits;
        hits = {2'b00, (w[4:0]   == s0)} + {2'b00, (w[9:5]   == s1)}
             + {2'b00, (w[14:10] == s2)} + {2'b00, (w[19:15] == s3)};
        return hits >= 3'd3;
    endfunction

endpackage

// File: rtl/pd_rx_framer_crc32_nib.sv
// Combinational CRC32 update for one nibble, reflected polynomial, LSB first.
module pd_rx_framer_crc32_nib
    import pd_rx_framer_pkg::*;
(
    input  logic [31:0] crc_in,
    input  logic [3:0]  nib,
    output logic [31:0] crc_out
);

    always_comb begin
        logic [31:0] c;
        c = crc_in;
        for (int i = 0; i < 4; i++) begin
            if (c[0] ^ nib[i]) c = (c >> 1) ^ CRC_POLY_REFL;
            else               c = c >> 1;
        end
        crc_out = c;
    end

endmodule

// File: rtl/pd_rx_framer.sv
// USB-PD receive framer: ordered-set hunt, 4b5b byte decode, EOP and CRC32
// residual check, idle timeout, one-byte-deep output holding.
module pd_rx_framer
    import pd_rx_framer_pkg::*;
#(
    parameter int system_khz  = 200000,
    parameter int IDLE_TMO_US = 5,
    parameter int MAX_BYTES   = 264
) (
    input  logic       clock,
    input  logic       nrst,
    input  logic       enable,
    input  logic       bit_valid,
    input  logic       bit_in,
    output logic       rx_start,
    output logic [2:0] sop_type,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_last,
    output logic       rx_crc_ok,
    output logic       rx_err,
    output logic       hard_reset,
    output logic       cable_reset,
    output logic       busy
);

    localparam int TMO_CYC = IDLE_TMO_US * system_khz / 1000;
    localparam int TMO_W   = $clog2(TMO_CYC + 1);
    localparam int BCNT_W  = $clog2(MAX_BYTES + 1);

    state_t              state_q, state_d;
    logic [19:0]         win_q, win_d;
    logic [2:0]          bit_cnt_q, bit_cnt_d;
    logic [BCNT_W-1:0]   byte_cnt_q, byte_cnt_d;
    logic [TMO_W-1:0]    tmo_cnt_q, tmo_cnt_d;
    logic [31:0]         crc_q, crc_d;
    logic                nib_hi_q, nib_hi_d;
    logic [3:0]          lo_nib_q, lo_nib_d;
    logic [7:0]          held_q, held_d;
    logic                held_vld_q, held_vld_d;

    logic                rx_start_q, rx_start_d;
    logic [2:0]          sop_type_q, sop_type_d;
    logic [7:0]          rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_last_q, rx_last_d;
    logic                rx_crc_ok_q, rx_crc_ok_d;
    logic                rx_err_q, rx_err_d;
    logic                hard_reset_q, hard_reset_d;
    logic                cable_reset_q, cable_reset_d;
    logic                busy_q, busy_d;

    logic [19:0]         win_shift;
    logic [4:0]          sym;
    dec_t                sym_dec;
    logic [31:0]         crc_nib;
    logic                hr_hit, cr_hit, sop_any;
    logic [4:0]          sop_hit;
    sop_t                sop_sel;
    logic                sym_done, tmo_hit, frame_err, eop_ok;

    pd_rx_framer_crc32_nib u_crc (
        .crc_in  (crc_q),
        .nib     (sym_dec.nib),
        .crc_out (crc_nib)
    );

    // Ordered-set hunt on the window as it will look after this bit.
    always_comb begin
        win_shift = {bit_in, win_q[19:1]};
        sym       = win_shift[19:15];
        sym_dec   = dec_4b5b(sym);
        hr_hit    = os_match(win_shift, K_RST1, K_RST1, K_RST1, K_RST2);
        cr_hit    = os_match(win_shift, K_RST1, K_SYNC1, K_RST1, K_SYNC3);
        sop_hit[0] = os_match(win_shift, K_SYNC1, K_SYNC1, K_SYNC1, K_SYNC2);
        sop_hit[1] = os_match(win_shift, K_SYNC1, K_SYNC1, K_SYNC3, K_SYNC3);
        sop_hit[2] = os_match(win_shift, K_SYNC1, K_SYNC3, K_SYNC1, K_SYNC3);
        sop_hit[3] = os_match(win_shift, K_SYNC1, K_RST2, K_RST2, K_SYNC3);
        sop_hit[4] = os_match(win_shift, K_SYNC1, K_RST2, K_SYNC3, K_SYNC2);
        sop_any   = |sop_hit;
        if      (sop_hit[0]) sop_sel = SOP_T;
        else if (sop_hit[1]) sop_sel = SOP_P;
        else if (sop_hit[2]) sop_sel = SOP_PP;
        else if (sop_hit[3]) sop_sel = SOP_P_DBG;
        else                 sop_sel = SOP_PP_DBG;
    end

    // Frame-level events; a timeout outranks a bit arriving in the same cycle.
    always_comb begin
        sym_done  = bit_valid && (bit_cnt_q == 3'd4);
        tmo_hit   = (tmo_cnt_q == TMO_W'(TMO_CYC - 1));
        frame_err = 1'b0;
        eop_ok    = 1'b0;
        if (state_q == ST_RECV) begin
            if (tmo_hit) begin
                frame_err = 1'b1;
            end else if (sym_done) begin
                if (sym == K_EOP) begin
                    if (nib_hi_q || (byte_cnt_q < BCNT_W'(MIN_FRAME_BYTES))) frame_err = 1'b1;
                    else                                                    eop_ok    = 1'b1;
                end else if (!sym_dec.vld) begin
                    frame_err = 1'b1;
                end else if (nib_hi_q && (byte_cnt_q == BCNT_W'(MAX_BYTES))) begin
                    frame_err = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_HUNT: if (bit_valid && !hr_hit && !cr_hit && sop_any) state_d = ST_RECV;
            ST_RECV: if (frame_err || eop_ok)                         state_d = ST_HUNT;
            default: state_d = ST_HUNT;
        endcase
    end

    always_comb begin
        win_d         = win_q;
        bit_cnt_d     = bit_cnt_q;
        byte_cnt_d    = byte_cnt_q;
        tmo_cnt_d     = '0;
        crc_d         = crc_q;
        nib_hi_d      = nib_hi_q;
        lo_nib_d      = lo_nib_q;
        held_d        = held_q;
        held_vld_d    = held_vld_q;
        rx_start_d    = 1'b0;
        sop_type_d    = sop_type_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_last_d     = 1'b0;
        rx_crc_ok_d   = 1'b0;
        rx_err_d      = 1'b0;
        hard_reset_d  = 1'b0;
        cable_reset_d = 1'b0;
        busy_d        = (state_d == ST_RECV);

        if (state_q == ST_HUNT) begin
            if (bit_valid) begin
                win_d = win_shift;
                if (hr_hit) begin
                    hard_reset_d = 1'b1;
                    win_d        = '0;
                end else if (cr_hit) begin
                    cable_reset_d = 1'b1;
                    win_d         = '0;
                end else if (sop_any) begin
                    rx_start_d = 1'b1;
                    sop_type_d = sop_sel;
                    win_d      = '0;
                    bit_cnt_d  = '0;
                    byte_cnt_d = '0;
                    crc_d      = CRC_INIT;
                    nib_hi_d   = 1'b0;
                    held_vld_d = 1'b0;
                end
            end
        end else begin
            tmo_cnt_d = bit_valid ? '0 : tmo_cnt_q + TMO_W'(1);
            if (frame_err) begin
                rx_err_d   = 1'b1;
                held_vld_d = 1'b0;
                win_d      = '0;
            end else if (bit_valid) begin
                win_d     = win_shift;
                bit_cnt_d = sym_done ? 3'd0 : bit_cnt_q + 3'd1;
                if (eop_ok) begin
                    rx_valid_d  = 1'b1;
                    rx_data_d   = held_q;
                    rx_last_d   = 1'b1;
                    rx_crc_ok_d = (crc_q == CRC_RESIDUE);
                    held_vld_d  = 1'b0;
                    win_d       = '0;
                end else if (sym_done) begin
                    crc_d = crc_nib;
                    if (!nib_hi_q) begin
                        lo_nib_d = sym_dec.nib;
                        nib_hi_d = 1'b1;
                        // The previous byte is only released once a following symbol proves it is not the CRC MSB.
                        if (held_vld_q) begin
                            rx_valid_d = 1'b1;
                            rx_data_d  = held_q;
                            held_vld_d = 1'b0;
                        end
                    end else begin
                        held_d     = {sym_dec.nib, lo_nib_q};
                        held_vld_d = 1'b1;
                        nib_hi_d   = 1'b0;
                        byte_cnt_d = byte_cnt_q + BCNT_W'(1);
                    end
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (!nrst || !enable) state_q <= ST_HUNT;
        else                  state_q <= state_d;
    end

    always_ff @(posedge clock) begin
        if (!nrst || !enable) begin
            win_q         <= '0;
            bit_cnt_q     <= '0;
            byte_cnt_q    <= '0;
            tmo_cnt_q     <= '0;
            crc_q         <= '0;
            nib_hi_q      <= 1'b0;
            lo_nib_q      <= '0;
            held_q        <= '0;
            held_vld_q    <= 1'b0;
            rx_start_q    <= 1'b0;
            sop_type_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_last_q     <= 1'b0;
            rx_crc_ok_q   <= 1'b0;
            rx_err_q      <= 1'b0;
            hard_reset_q  <= 1'b0;
            cable_reset_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            win_q         <= win_d;
            bit_cnt_q     <= bit_cnt_d;
            byte_cnt_q    <= byte_cnt_d;
            tmo_cnt_q     <= tmo_cnt_d;
            crc_q         <= crc_d;
            nib_hi_q      <= nib_hi_d;
            lo_nib_q      <= lo_nib_d;
            held_q        <= held_d;
            held_vld_q    <= held_vld_d;
            rx_start_q    <= rx_start_d;
            sop_type_q    <= sop_type_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_last_q     <= rx_last_d;
            rx_crc_ok_q   <= rx_crc_ok_d;
            rx_err_q      <= rx_err_d;
            hard_reset_q  <= hard_reset_d;
            cable_reset_q <= cable_reset_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_start    = rx_start_q;
    assign sop_type    = sop_type_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_last     = rx_last_q;
    assign rx_crc_ok   = rx_crc_ok_q;
    assign rx_err      = rx_err_q;
    assign hard_reset  = hard_reset_q;
    assign cable_reset = cable_reset_q;
    assign busy        = busy_q;

endmodule
